// File: rtl/ct_ifu_l0btb_pkg.sv
// Shared constants for the IFU L0 BTB write-side logic: entry count,
// field widths, write-enable bit positions and the pending-refresh record.
package ct_ifu_l0btb_pkg;

   localparam int L0BTB_ENTRY_NUM = 16;
   localparam int L0BTB_IDX_W     = 4;

   localparam int L0BTB_TAG_W     = 15;
   localparam int L0BTB_WAY_W     = 2;
   localparam int L0BTB_TGT_W     = 20;
   localparam int L0BTB_DATA_W    = L0BTB_TAG_W + L0BTB_WAY_W + L0BTB_TGT_W;

   localparam int L0BTB_WEN_W     = 4;
   localparam int WEN_VLD         = 3;
   localparam int WEN_CNT         = 2;
   localparam int WEN_RAS         = 1;
   localparam int WEN_DATA        = 0;

   // One buffered counter refresh that lost arbitration to an allocation.
   typedef struct packed {
      logic                   vld;
      logic [L0BTB_IDX_W-1:0] idx;
      logic                   val;
   } l0btb_pend_t;

   // Entry index to one-hot entry select.
   function automatic logic [L0BTB_ENTRY_NUM-1:0] l0btb_onehot(
      input logic [L0BTB_IDX_W-1:0] idx
   );
      logic [L0BTB_ENTRY_NUM-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/ct_ifu_l0_btb_wr_ctrl_if.sv
// Request/entry-write bundle of the L0 BTB write controller.
// Handshake: a request (inv_req / alloc_vld / cnt_upd_vld) is a single-cycle
// strobe with no back-pressure; alloc_ack is high in the same cycle an
// allocation is accepted, and entry_* outputs are registered one cycle later.
interface ct_ifu_l0_btb_wr_ctrl_if;
   import ct_ifu_l0btb_pkg::*;

   logic                       cp0_ifu_btb_en;
   logic                       cp0_ifu_l0btb_en;
   logic                       inv_req;
   logic                       alloc_vld;
   logic [L0BTB_DATA_W-1:0]    alloc_data;
   logic                       alloc_cnt;
   logic                       alloc_ras;
   logic [L0BTB_ENTRY_NUM-1:0] alloc_hit_vec;
   logic                       cnt_upd_vld;
   logic [L0BTB_IDX_W-1:0]     cnt_upd_idx;
   logic                       cnt_upd_val;

   logic                       alloc_ack;
   logic [L0BTB_ENTRY_NUM-1:0] entry_update;
   logic [L0BTB_WEN_W-1:0]     entry_wen;
   logic [L0BTB_DATA_W-1:0]    entry_update_data;
   logic                       entry_update_vld;
   logic                       entry_update_cnt;
   logic                       entry_update_ras;
   logic                       entry_inv;

   modport slave (
      input  cp0_ifu_btb_en, cp0_ifu_l0btb_en, inv_req, alloc_vld, alloc_data,
             alloc_cnt, alloc_ras, alloc_hit_vec, cnt_upd_vld, cnt_upd_idx,
             cnt_upd_val,
      output alloc_ack, entry_update, entry_wen, entry_update_data,
             entry_update_vld, entry_update_cnt, entry_update_ras, entry_inv
   );

   modport master (
      output cp0_ifu_btb_en, cp0_ifu_l0btb_en, inv_req, alloc_vld, alloc_data,
             alloc_cnt, alloc_ras, alloc_hit_vec, cnt_upd_vld, cnt_upd_idx,
             cnt_upd_val,
      input  alloc_ack, entry_update, entry_wen, entry_update_data,
             entry_update_vld, entry_update_cnt, entry_update_ras, entry_inv
   );

endinterface

// File: rtl/ct_ifu_l0btb_victim_ptr.sv
// Round-robin victim pointer for L0 BTB allocation; wraps 15 -> 0.
module ct_ifu_l0btb_victim_ptr
   import ct_ifu_l0btb_pkg::*;
(
   input  logic                   entry_clk,
   input  logic                   cpurst_b,
   input  logic                   ptr_clr,
   input  logic                   ptr_inc,
   output logic [L0BTB_IDX_W-1:0] ptr
);

   logic [L0BTB_IDX_W-1:0] ptr_q;

   // Clear has priority over increment; natural 4-bit overflow gives the wrap.
   always_ff @(posedge entry_clk or negedge cpurst_b) begin
      if (!cpurst_b)
         ptr_q <= '0;
      else if (ptr_clr)
         ptr_q <= '0;
      else if (ptr_inc)
         ptr_q <= ptr_q + L0BTB_IDX_W'(1);
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/ct_ifu_l0_btb_wr_ctrl.sv
// Write-side controller of the 16-entry IFU L0 BTB: arbitrates
// invalidate-all > allocation > counter refresh and drives registered
// entry select / field enables / write data.
// Optional feature macro: CT_IFU_L0BTB_UPD_BUF_EN keeps a one-deep buffer
// for a counter refresh that lost to an allocation; without it such a
// refresh is dropped.
module ct_ifu_l0_btb_wr_ctrl
   import ct_ifu_l0btb_pkg::*;
(
   input  logic                    entry_clk,
   input  logic                    cpurst_b,
   ct_ifu_l0_btb_wr_ctrl_if.slave  bus
);

   logic                       ctrl_en;
   logic                       inv_sel;
   logic                       alloc_sel;
   logic                       cnt_sel;
   logic                       alloc_hit;
   logic [L0BTB_IDX_W-1:0]     victim_ptr;
   logic [L0BTB_ENTRY_NUM-1:0] alloc_tgt_vec;

   logic                       pend_vld;
   logic [L0BTB_IDX_W-1:0]     pend_idx;
   logic                       pend_val;

   logic [L0BTB_ENTRY_NUM-1:0] upd_d,   upd_q;
   logic [L0BTB_WEN_W-1:0]     wen_d,   wen_q;
   logic [L0BTB_DATA_W-1:0]    data_d,  data_q;
   logic                       vld_d,   vld_q;
   logic                       cnt_d,   cnt_q;
   logic                       ras_d,   ras_q;
   logic                       inv_d,   inv_q;

   // Both enables gate sampling only; an already registered command still issues.
   assign ctrl_en       = bus.cp0_ifu_btb_en & bus.cp0_ifu_l0btb_en;
   assign inv_sel       = ctrl_en & bus.inv_req;
   assign alloc_sel     = ctrl_en & ~bus.inv_req & bus.alloc_vld;
   assign cnt_sel       = ctrl_en & bus.cnt_upd_vld;
   assign alloc_hit     = |bus.alloc_hit_vec;
   assign alloc_tgt_vec = alloc_hit ? bus.alloc_hit_vec : l0btb_onehot(victim_ptr);
   assign bus.alloc_ack = alloc_sel;

   ct_ifu_l0btb_victim_ptr u_victim_ptr (
      .entry_clk (entry_clk),
      .cpurst_b  (cpurst_b),
      .ptr_clr   (inv_sel),
      .ptr_inc   (alloc_sel & ~alloc_hit),
      .ptr       (victim_ptr)
   );

`ifdef CT_IFU_L0BTB_UPD_BUF_EN
   l0btb_pend_t pend_d, pend_q;

   // Buffer a refresh that loses to an allocation (newest wins); drop it when
   // the allocation rewrites that same entry or once it has been issued.
   always_comb begin
      pend_d = pend_q;
      if (inv_sel) begin
         pend_d = '0;
      end else if (alloc_sel) begin
         if (cnt_sel) begin
            pend_d.vld = 1'b1;
            pend_d.idx = bus.cnt_upd_idx;
            pend_d.val = bus.cnt_upd_val;
         end
         if (pend_d.vld && alloc_tgt_vec[pend_d.idx])
            pend_d.vld = 1'b0;
      end else if (ctrl_en) begin
         pend_d = '0;
      end
   end

   // Pending refresh register; lost on reset.
   always_ff @(posedge entry_clk or negedge cpurst_b) begin
      if (!cpurst_b)
         pend_q <= '0;
      else
         pend_q <= pend_d;
   end

   assign pend_vld = pend_q.vld;
   assign pend_idx = pend_q.idx;
   assign pend_val = pend_q.val;
`else
   assign pend_vld = 1'b0;
   assign pend_idx = '0;
   assign pend_val = 1'b0;
`endif

   // Arbitrate the sampled requests into next-cycle write command.
   always_comb begin
      upd_d  = '0;
      wen_d  = '0;
      data_d = '0;
      vld_d  = 1'b0;
      cnt_d  = 1'b0;
      ras_d  = 1'b0;
      inv_d  = 1'b0;
      if (inv_sel) begin
         inv_d = 1'b1;
      end else if (alloc_sel) begin
         upd_d  = alloc_tgt_vec;
         wen_d  = '1;
         data_d = bus.alloc_data;
         vld_d  = 1'b1;
         cnt_d  = bus.alloc_cnt;
         ras_d  = bus.alloc_ras;
      end else if (cnt_sel) begin
         upd_d          = l0btb_onehot(bus.cnt_upd_idx);
         wen_d[WEN_CNT] = 1'b1;
         cnt_d          = bus.cnt_upd_val;
      end else if (ctrl_en && pend_vld) begin
         upd_d          = l0btb_onehot(pend_idx);
         wen_d[WEN_CNT] = 1'b1;
         cnt_d          = pend_val;
      end
   end

   // Registered write command; reset clears any in-flight command at once.
   always_ff @(posedge entry_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         upd_q  <= '0;
         wen_q  <= '0;
         data_q <= '0;
         vld_q  <= 1'b0;
         cnt_q  <= 1'b0;
         ras_q  <= 1'b0;
         inv_q  <= 1'b0;
      end else begin
         upd_q  <= upd_d;
         wen_q  <= wen_d;
         data_q <= data_d;
         vld_q  <= vld_d;
         cnt_q  <= cnt_d;
         ras_q  <= ras_d;
         inv_q  <= inv_d;
      end
   end

   assign bus.entry_update      = upd_q;
   assign bus.entry_wen         = wen_q;
   assign bus.entry_update_data = data_q;
   assign bus.entry_update_vld  = vld_q;
   assign bus.entry_update_cnt  = cnt_q;
   assign bus.entry_update_ras  = ras_q;
   assign bus.entry_inv         = inv_q;

endmodule

// File: tb/tb_ct_ifu_l0_btb_wr_ctrl.sv
// Bench for ct_ifu_l0_btb_wr_ctrl: directed steps followed by random traffic,
// each compared against a behavioural model of the write controller.
module tb_ct_ifu_l0_btb_wr_ctrl;

   logic entry_clk;
   logic cpurst_b;
   int   n_assert;
   int   n_fail;

   ct_ifu_l0_btb_wr_ctrl_if bus();

   ct_ifu_l0_btb_wr_ctrl dut (
      .entry_clk (entry_clk),
      .cpurst_b  (cpurst_b),
      .bus       (bus)
   );

   // Clock
   initial entry_clk = 1'b0;
   always #5 entry_clk = ~entry_clk;

   // Model state: victim pointer, pending refresh, expected next outputs.
   int          m_ptr;
   bit          m_pv;
   int          m_pidx;
   bit          m_pval;
   logic [15:0] e_upd;
   logic [3:0]  e_wen;
   logic [36:0] e_data;
   logic        e_vld, e_cnt, e_ras, e_inv;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_pv = 0; m_pidx = 0; m_pval = 0;
      e_upd = '0; e_wen = '0; e_data = '0;
      e_vld = 0; e_cnt = 0; e_ras = 0; e_inv = 0;
   endtask

   task automatic check_outputs();
      chk("entry_update", 64'(bus.entry_update), 64'(e_upd));
      chk("entry_wen",    64'(bus.entry_wen),    64'(e_wen));
      chk("entry_data",   64'(bus.entry_update_data), 64'(e_data));
      chk("entry_vld",    64'(bus.entry_update_vld),  64'(e_vld));
      chk("entry_cnt",    64'(bus.entry_update_cnt),  64'(e_cnt));
      chk("entry_ras",    64'(bus.entry_update_ras),  64'(e_ras));
      chk("entry_inv",    64'(bus.entry_inv),         64'(e_inv));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_update"}, 64'(bus.entry_update), 64'(0));
      chk({tag, "_wen"},    64'(bus.entry_wen),    64'(0));
      chk({tag, "_data"},   64'(bus.entry_update_data), 64'(0));
      chk({tag, "_vld"},    64'(bus.entry_update_vld),  64'(0));
      chk({tag, "_cnt"},    64'(bus.entry_update_cnt),  64'(0));
      chk({tag, "_ras"},    64'(bus.entry_update_ras),  64'(0));
      chk({tag, "_inv"},    64'(bus.entry_inv),         64'(0));
   endtask

   // One sampling cycle: check last registered command, drive new request,
   // check combinational ack, then advance the model.
   task automatic cycle(input bit inv, input bit alloc, input logic [15:0] hv,
                        input bit cnt, input int idx, input bit val,
                        input bit ben, input bit len);
      logic [36:0] d;
      bit          a_cnt, a_ras, en, ack;
      int          tgt;
      d     = 37'({$urandom(), $urandom()});
      a_cnt = 1'($urandom_range(0, 1));
      a_ras = 1'($urandom_range(0, 1));
      @(negedge entry_clk);
      check_outputs();
      assert ($onehot0(hv)) else begin
         n_fail++;
         $error("FAIL hit_vec_onehot observed=%0h expected=onehot0", hv);
      end
      bus.inv_req          = inv;
      bus.alloc_vld        = alloc;
      bus.alloc_hit_vec    = hv;
      bus.alloc_data       = d;
      bus.alloc_cnt        = a_cnt;
      bus.alloc_ras        = a_ras;
      bus.cnt_upd_vld      = cnt;
      bus.cnt_upd_idx      = 4'(idx);
      bus.cnt_upd_val      = val;
      bus.cp0_ifu_btb_en   = ben;
      bus.cp0_ifu_l0btb_en = len;
      #1;
      en  = ben && len;
      ack = en && !inv && alloc;
      chk("alloc_ack", 64'(bus.alloc_ack), 64'(ack));
      // Advance model
      e_upd = '0; e_wen = '0; e_data = '0;
      e_vld = 0; e_cnt = 0; e_ras = 0; e_inv = 0;
      if (en && inv) begin
         e_inv = 1; m_ptr = 0; m_pv = 0;
      end else if (ack) begin
         tgt = m_ptr;
         for (int i = 0; i < 16; i++) if (hv[i]) tgt = i;
         e_upd = 16'(1) << tgt;
         e_wen = 4'hF; e_data = d; e_vld = 1; e_cnt = a_cnt; e_ras = a_ras;
         if (hv == 0) m_ptr = (m_ptr + 1) % 16;
`ifdef CT_IFU_L0BTB_UPD_BUF_EN
         if (cnt) begin
            m_pv = 1; m_pidx = idx; m_pval = val;
         end
         if (m_pv && m_pidx == tgt) m_pv = 0;
`endif
      end else if (en && cnt) begin
         e_upd = 16'(1) << idx; e_wen = 4'b0100; e_cnt = val;
         m_pv = 0;
      end else if (en && m_pv) begin
         e_upd = 16'(1) << m_pidx; e_wen = 4'b0100; e_cnt = m_pval;
         m_pv = 0;
      end
   endtask

   task automatic idle();
      cycle(0, 0, 16'h0, 0, 0, 0, 1, 1);
   endtask

   task automatic alloc0();
      cycle(0, 1, 16'h0, 0, 0, 0, 1, 1);
   endtask

   // Directed steps then random traffic.
   initial begin
      n_assert = 0;
      n_fail   = 0;
      cpurst_b = 1'b0;
      bus.inv_req = 0; bus.alloc_vld = 0; bus.alloc_hit_vec = '0;
      bus.alloc_data = '0; bus.alloc_cnt = 0; bus.alloc_ras = 0;
      bus.cnt_upd_vld = 0; bus.cnt_upd_idx = '0; bus.cnt_upd_val = 0;
      bus.cp0_ifu_btb_en = 1; bus.cp0_ifu_l0btb_en = 1;
      model_reset();
      #1;
      check_zero("reset");
      @(negedge entry_clk);
      @(negedge entry_clk);
      cpurst_b = 1'b1;

      // 17 allocations walk the pointer 0..15 then wrap to 0.
      for (int i = 0; i < 17; i++) alloc0();
      idle();
      chk("wrap_update", 64'(bus.entry_update), 64'(16'h0001));

      // Pointer to 3, then a dedup hit on entry 5 keeps it at 3.
      alloc0(); alloc0();
      cycle(0, 1, 16'h0020, 0, 0, 0, 1, 1);
      alloc0();
      chk("dedup_update", 64'(bus.entry_update), 64'(16'h0020));
      idle();
      chk("after_dedup_update", 64'(bus.entry_update), 64'(16'h0008));

      // Alloc (entry 4) and refresh idx 7 in the same cycle.
      cycle(0, 1, 16'h0, 1, 7, 1, 1, 1);
      idle();
      chk("collide_alloc", 64'(bus.entry_update), 64'(16'h0010));
      idle();
`ifdef CT_IFU_L0BTB_UPD_BUF_EN
      chk("buffered_update", 64'(bus.entry_update), 64'(16'h0080));
      chk("buffered_wen",    64'(bus.entry_wen),    64'(4'b0100));
      chk("buffered_cnt",    64'(bus.entry_update_cnt), 64'(1));
`else
      chk("dropped_update",  64'(bus.entry_update), 64'(0));
      chk("dropped_wen",     64'(bus.entry_wen),    64'(0));
`endif

      // Pointer 5 -> 9, then invalidate with a concurrent alloc.
      for (int i = 0; i < 4; i++) alloc0();
      cycle(1, 1, 16'h0, 1, 3, 1, 1, 1);
      alloc0();
      chk("inv_pulse", 64'(bus.entry_inv), 64'(1));
      chk("inv_update", 64'(bus.entry_update), 64'(0));
      idle();
      chk("post_inv_alloc", 64'(bus.entry_update), 64'(16'h0001));

      // L0 BTB disabled with alloc held: nothing issues, pointer frozen at 1.
      for (int i = 0; i < 3; i++) cycle(0, 1, 16'h0, 1, 2, 1, 1, 0);
      alloc0();
      idle();
      chk("post_disable_alloc", 64'(bus.entry_update), 64'(16'h0002));

      // Reset while a refresh is buffered.
      cycle(0, 1, 16'h0, 1, 5, 1, 1, 1);
      idle();
      cpurst_b = 1'b0;
      #1;
      check_zero("mid_reset");
      model_reset();
      @(negedge entry_clk);
      @(negedge entry_clk);
      cpurst_b = 1'b1;
      idle(); idle(); idle();
      alloc0();
      idle();
      chk("post_reset_alloc", 64'(bus.entry_update), 64'(16'h0001));

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         bit          r_inv, r_alloc, r_cnt, r_val, r_ben, r_len;
         logic [15:0] r_hv;
         int          r_idx;
         r_inv   = ($urandom_range(0, 31) == 0);
         r_alloc = 1'($urandom_range(0, 1));
         r_cnt   = 1'($urandom_range(0, 1));
         r_val   = 1'($urandom_range(0, 1));
         r_idx   = $urandom_range(0, 15);
         r_hv    = ($urandom_range(0, 3) == 0) ? (16'(1) << $urandom_range(0, 15)) : 16'h0;
         r_ben   = ($urandom_range(0, 15) != 0);
         r_len   = ($urandom_range(0, 15) != 0);
         cycle(r_inv, r_alloc, r_hv, r_cnt, r_idx, r_val, r_ben, r_len);
      end
      idle();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
